// File: rtl/dma_desc_sched.sv
// Descriptor-chain scheduler: fetches 4-word descriptors over a read master and launches the engine per descriptor.
// Defining DMA_DESC_TIMEOUT_EN adds a read-response watchdog of TIMEOUT_CYC cycles.

module dma_desc_sched #(
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 24,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go_i,
  input  logic              stop_i,
  input  logic [ADDR_W-1:0] desc_ptr_i,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic              m_rd_o,
  input  logic              m_wait_rq_i,
  input  logic              m_rd_valid_i,
  input  logic [31:0]       m_rd_data_i,
  output logic [ADDR_W-1:0] eng_src_o,
  output logic [ADDR_W-1:0] eng_dst_o,
  output logic [LEN_W-1:0]  eng_len_o,
  output logic              eng_start_o,
  input  logic              eng_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              abort_o,
  output logic [CNT_W-1:0]  desc_cnt_o
);

  // The launch decision is taken as the last word is captured, so there is no separate launch state.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    XFER    = 3'd3,
    NEXT    = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        idx;
  logic [ADDR_W-1:0] src_w;
  logic [ADDR_W-1:0] dst_w;
  logic [LEN_W-1:0]  len_w;
  logic [27:0]       nxt_w;
  logic              last_w;

`ifdef DMA_DESC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base, input logic [1:0] i);
    return base + ADDR_W'({i, 2'b00});
  endfunction

  // Chain sequencer with registered master, engine and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= {ADDR_W{1'b0}};
      idx         <= 2'd0;
      src_w       <= {ADDR_W{1'b0}};
      dst_w       <= {ADDR_W{1'b0}};
      len_w       <= {LEN_W{1'b0}};
      nxt_w       <= 28'd0;
      last_w      <= 1'b0;
      m_addr_o    <= {ADDR_W{1'b0}};
      m_rd_o      <= 1'b0;
      eng_src_o   <= {ADDR_W{1'b0}};
      eng_dst_o   <= {ADDR_W{1'b0}};
      eng_len_o   <= {LEN_W{1'b0}};
      eng_start_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      abort_o     <= 1'b0;
      desc_cnt_o  <= {CNT_W{1'b0}};
`ifdef DMA_DESC_TIMEOUT_EN
      tmo_cnt     <= {TMO_W{1'b0}};
`endif
    end else begin
      eng_start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (go_i) begin
            if (desc_ptr_i[3:0] == 4'h0) begin
              ptr        <= desc_ptr_i;
              idx        <= 2'd0;
              m_addr_o   <= desc_ptr_i;
              m_rd_o     <= 1'b1;
              busy_o     <= 1'b1;
              done_o     <= 1'b0;
              err_o      <= 1'b0;
              abort_o    <= 1'b0;
              desc_cnt_o <= {CNT_W{1'b0}};
              state      <= RD_REQ;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          // Once the fabric has taken the request, stop is honoured only after its data returns.
          if (!m_wait_rq_i) begin
            m_rd_o <= 1'b0;
            state  <= RD_WAIT;
`ifdef DMA_DESC_TIMEOUT_EN
            tmo_cnt <= {TMO_W{1'b0}};
`endif
          end else if (stop_i) begin
            m_rd_o  <= 1'b0;
            abort_o <= 1'b1;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end
        end
        RD_WAIT: begin
          if (m_rd_valid_i) begin
            case (idx)
              2'd0:    src_w <= ADDR_W'(m_rd_data_i);
              2'd1:    dst_w <= ADDR_W'(m_rd_data_i);
              2'd2:    len_w <= m_rd_data_i[LEN_W-1:0];
              default: begin
                nxt_w  <= m_rd_data_i[31:4];
                last_w <= m_rd_data_i[0];
              end
            endcase
            if (stop_i) begin
              abort_o <= 1'b1;
              busy_o  <= 1'b0;
              state   <= IDLE;
            end else if (idx != 2'd3) begin
              idx      <= idx + 2'd1;
              m_addr_o <= word_addr(ptr, idx + 2'd1);
              m_rd_o   <= 1'b1;
              state    <= RD_REQ;
            end else if (len_w != {LEN_W{1'b0}}) begin
              eng_src_o   <= src_w;
              eng_dst_o   <= dst_w;
              eng_len_o   <= len_w;
              eng_start_o <= 1'b1;
              state       <= XFER;
            end else begin
              state <= NEXT;
            end
          end
`ifdef DMA_DESC_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            err_o  <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        XFER: begin
          if (eng_done_i) begin
            state <= NEXT;
          end
        end
        NEXT: begin
          if (desc_cnt_o != {CNT_W{1'b1}}) begin
            desc_cnt_o <= desc_cnt_o + CNT_W'(1);
          end
          if (stop_i) begin
            abort_o <= 1'b1;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end else if (last_w || (nxt_w == 28'd0)) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            ptr      <= ADDR_W'({nxt_w, 4'h0});
            idx      <= 2'd0;
            m_addr_o <= ADDR_W'({nxt_w, 4'h0});
            m_rd_o   <= 1'b1;
            state    <= RD_REQ;
          end
        end
        default: begin
          m_rd_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
